// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the data-memory responder
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } resp_state_e;

    // Wide enough for WAIT_CYCLES in 0..15
    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane enables, write replication and read extraction
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    input  logic        sign_ext,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic        misalign,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    // Selected lane(s) moved down to bit 0 for extraction
    assign shifted = rword >> {offset, 3'b000};

    // Decode access size into lanes; store data is replicated so any enabled lane sees it
    always_comb begin
        byte_en  = 4'b0000;
        wword    = wdata;
        misalign = 1'b0;
        rdata    = 32'h0;
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << offset;
                wword   = {4{wdata[7:0]}};
                rdata   = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                misalign = offset[0];
                byte_en  = offset[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                rdata    = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                misalign = (offset != 2'b00);
                byte_en  = 4'b1111;
                rdata    = rword;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multicycle word RAM answering load/store requests with a Ready pulse
module data_mem_responder
    import mips_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemoryRead,
    input  logic        MemoryWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [1:0]  Size,
    input  logic        SignExtend,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        AddrError
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    resp_state_e       state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic              write_q, write_d;
    logic              both_q, both_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              aerr_q, aerr_d;

    logic [31:0]       mem [DEPTH];

    logic              idle, commit, acc_err, do_write;
    logic [ADDR_W+1:0] acc_addr;
    logic [31:0]       acc_wdata, rword, wword, ext_rdata;
    logic [1:0]        acc_size;
    logic              acc_sext, acc_write, acc_both, misalign;
    logic [3:0]        byte_en;
    logic              unused_addr_hi;

    // With zero wait cycles the commit happens on the sampling edge, so use live inputs in IDLE
    assign idle      = (state_q == ST_IDLE);
    assign acc_addr  = idle ? Address[ADDR_W+1:0] : addr_q;
    assign acc_wdata = idle ? WriteData : wdata_q;
    assign acc_size  = idle ? Size : size_q;
    assign acc_sext  = idle ? SignExtend : sext_q;
    assign acc_write = idle ? MemoryWrite : write_q;
    assign acc_both  = idle ? (MemoryRead & MemoryWrite) : both_q;

    // Upper address bits wrap around
    assign unused_addr_hi = ^Address[31:ADDR_W+2];

    assign rword    = mem[acc_addr[ADDR_W+1:2]];
    assign acc_err  = misalign | acc_both;
    assign do_write = commit & acc_write & ~acc_err & rst;

    mem_lane_align u_align (
        .size     (acc_size),
        .offset   (acc_addr[1:0]),
        .wdata    (acc_wdata),
        .rword    (rword),
        .sign_ext (acc_sext),
        .byte_en  (byte_en),
        .wword    (wword),
        .misalign (misalign),
        .rdata    (ext_rdata)
    );

    // Next-state, request latching and commit strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sext_d  = sext_q;
        write_d = write_q;
        both_d  = both_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemoryRead || MemoryWrite) begin
                    addr_d  = Address[ADDR_W+1:0];
                    wdata_d = WriteData;
                    size_d  = Size;
                    sext_d  = SignExtend;
                    write_d = MemoryWrite;
                    both_d  = MemoryRead & MemoryWrite;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= WAIT_W'(1)) begin
                    state_d = ST_DONE;
                    commit  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result registers update only on the edge entering DONE
    always_comb begin
        rdata_d = rdata_q;
        aerr_d  = aerr_q;
        if (commit) begin
            aerr_d  = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'h0 : ext_rdata;
        end
    end

    // Control and result state; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            write_q <= 1'b0;
            both_q  <= 1'b0;
            rdata_q <= '0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            write_q <= write_d;
            both_q  <= both_d;
            rdata_q <= rdata_d;
            aerr_q  <= aerr_d;
        end
    end

    // RAM array, not reset; only enabled lanes are written
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (do_write && byte_en[b]) begin
                mem[acc_addr[ADDR_W+1:2]][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign Ready     = (state_q == ST_DONE);
    assign ReadData  = rdata_q;
    assign AddrError = aerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - byte-level model bench for two responder configurations
module tb_data_mem_responder;

    localparam int WAITS [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mr [2];
    logic        mw [2];
    logic        sx [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [1:0]  sz [2];
    logic [31:0] rdo [2];
    logic        rdy [2];
    logic        aer [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]  bm [2][1024];
    bit          pend_v [2];
    int          pend_c [2];
    logic [31:0] pend_d [2];
    bit          pend_e [2];
    bit          pend_rd [2];
    bit          pend_wr [2];
    int          pend_base [2];
    int          pend_n [2];
    logic [31:0] pend_wdata [2];
    int          obs_c [2];
    logic [31:0] obs_d [2];
    bit          obs_e [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst_n), .MemoryRead(mr[0]), .MemoryWrite(mw[0]),
        .Address(ad[0]), .WriteData(wd[0]), .Size(sz[0]), .SignExtend(sx[0]),
        .ReadData(rdo[0]), .Ready(rdy[0]), .AddrError(aer[0])
    );

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst_n), .MemoryRead(mr[1]), .MemoryWrite(mw[1]),
        .Address(ad[1]), .WriteData(wd[1]), .Size(sz[1]), .SignExtend(sx[1]),
        .ReadData(rdo[1]), .Ready(rdy[1]), .AddrError(aer[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Byte-addressed memory model: expected error flag and load value
    function automatic void model(input int i, input bit rd, input bit wr, input logic [31:0] a,
                                  input logic [1:0] s, input bit x,
                                  output bit e, output logic [31:0] d, output int n);
        logic [63:0] v;
        int base;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        e = (rd && wr) || (s == 2'd3) || ((int'(a[1:0]) % n) != 0);
        base = int'(a[9:0]);
        v = 64'd0;
        for (int j = 0; j < n; j++) v = v | (64'(bm[i][(base + j) % 1024]) << (8 * j));
        if (x && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        d = (e || !rd) ? 32'h0 : v[31:0];
    endfunction

    // Every cycle: Ready must match the model schedule; results checked on the pulse
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit exp_r;
            exp_r = pend_v[i] && (cyc == pend_c[i]);
            chk($sformatf("ready_%0d", i), {31'b0, rdy[i]}, {31'b0, exp_r});
            if (exp_r) begin
                if (pend_rd[i]) chk($sformatf("rdata_%0d", i), rdo[i], pend_d[i]);
                chk($sformatf("addrerr_%0d", i), {31'b0, aer[i]}, {31'b0, pend_e[i]});
                if (pend_wr[i] && !pend_e[i])
                    for (int j = 0; j < pend_n[i]; j++)
                        bm[i][(pend_base[i] + j) % 1024] = pend_wdata[i][8*j +: 8];
                obs_c[i]  = cyc;
                obs_d[i]  = rdo[i];
                obs_e[i]  = aer[i];
                pend_v[i] = 1'b0;
            end
        end
    end

    task automatic access(input int i, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s, input bit x,
                          input bit lit, input logic [31:0] ld, input bit le, input int ll,
                          input string nm);
        bit e;
        logic [31:0] md;
        int n, k, t;
        @(negedge clk);
        mr[i] = rd; mw[i] = wr; ad[i] = a; wd[i] = d; sz[i] = s; sx[i] = x;
        @(posedge clk);
        #1;
        k = cyc;
        model(i, rd, wr, a, s, x, e, md, n);
        pend_rd[i] = rd; pend_wr[i] = wr; pend_e[i] = e; pend_d[i] = md;
        pend_base[i] = int'(a[9:0]); pend_n[i] = n; pend_wdata[i] = d;
        pend_c[i] = k + WAITS[i];
        pend_v[i] = 1'b1;
        @(negedge clk);
        mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = 32'hFFFF_FFFC; wd[i] = ~d; sz[i] = 2'd3; sx[i] = ~x;
        t = 0;
        while (pend_v[i] && t < 40) begin
            @(posedge clk);
            t++;
        end
        if (pend_v[i]) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=no_ready required=ready", nm);
            pend_v[i] = 1'b0;
        end else if (lit) begin
            chk({nm, "_lat"}, 32'(obs_c[i] - k + 1), 32'(ll));
            chk({nm, "_err"}, {31'b0, obs_e[i]}, {31'b0, le});
            if (rd) chk({nm, "_data"}, obs_d[i], ld);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_ready_%0d", nm, i), {31'b0, rdy[i]}, 32'h0);
            chk($sformatf("%s_aerr_%0d", nm, i), {31'b0, aer[i]}, 32'h0);
            chk($sformatf("%s_rdata_%0d", nm, i), rdo[i], 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mr[i] = 1'b0; mw[i] = 1'b0; sx[i] = 1'b0; ad[i] = '0; wd[i] = '0; sz[i] = '0;
            pend_v[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Known contents at 0x10, then a store aborted by reset mid-BUSY
        access(0, 0, 1, 32'h10, 32'h1111_1111, 2'd2, 0, 1, 32'h0, 0, 3, "st_10");
        @(negedge clk);
        mr[0] = 1'b0; mw[0] = 1'b1; ad[0] = 32'h10; wd[0] = 32'hDEAD_BEEF; sz[0] = 2'd2;
        @(posedge clk);
        @(negedge clk);
        mw[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_busy");
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1, 0, 32'h10, 32'h0, 2'd2, 0, 1, 32'h1111_1111, 0, 3, "ld_10_after_abort");

        // Word, byte and half accesses with WAIT_CYCLES=2
        access(0, 0, 1, 32'h20, 32'h1234_5678, 2'd2, 0, 1, 32'h0, 0, 3, "st_w20");
        access(0, 1, 0, 32'h20, 32'h0, 2'd2, 0, 1, 32'h1234_5678, 0, 3, "ld_w20");
        access(0, 0, 1, 32'h21, 32'h0000_00AB, 2'd0, 0, 1, 32'h0, 0, 3, "st_b21");
        access(0, 1, 0, 32'h20, 32'h0, 2'd2, 0, 1, 32'h1234_AB78, 0, 3, "ld_w20_b");
        access(0, 1, 0, 32'h21, 32'h0, 2'd0, 1, 1, 32'hFFFF_FFAB, 0, 3, "ld_b21_s");
        access(0, 1, 0, 32'h21, 32'h0, 2'd0, 0, 1, 32'h0000_00AB, 0, 3, "ld_b21_u");
        access(0, 0, 1, 32'h22, 32'h0000_8001, 2'd1, 0, 1, 32'h0, 0, 3, "st_h22");
        access(0, 1, 0, 32'h22, 32'h0, 2'd1, 1, 1, 32'hFFFF_8001, 0, 3, "ld_h22_s");
        access(0, 1, 0, 32'h22, 32'h0, 2'd1, 0, 1, 32'h0000_8001, 0, 3, "ld_h22_u");
        access(0, 1, 0, 32'h23, 32'h0, 2'd1, 1, 1, 32'h0, 1, 3, "ld_h23_err");
        access(0, 0, 1, 32'h23, 32'h0000_FFFF, 2'd1, 0, 1, 32'h0, 1, 3, "st_h23_err");
        access(0, 0, 1, 32'h22, 32'h5555_5555, 2'd2, 0, 1, 32'h0, 1, 3, "st_w22_err");
        access(0, 1, 0, 32'h20, 32'h0, 2'd2, 0, 1, 32'h8001_AB78, 0, 3, "ld_w20_unch");

        // Other error forms
        access(0, 1, 1, 32'h20, 32'h0BAD_0BAD, 2'd2, 0, 1, 32'h0, 1, 3, "both_err");
        access(0, 1, 0, 32'h20, 32'h0, 2'd3, 0, 1, 32'h0, 1, 3, "size11_err");
        access(0, 1, 0, 32'h20, 32'h0, 2'd2, 0, 1, 32'h8001_AB78, 0, 3, "ld_w20_after_both");

        // Address aliasing above ADDR_W+1
        access(0, 1, 0, 32'h420, 32'h0, 2'd2, 0, 1, 32'h8001_AB78, 0, 3, "alias_420");
        access(0, 1, 0, 32'h8000_0020, 32'h0, 2'd2, 0, 1, 32'h8001_AB78, 0, 3, "alias_hi");
        access(0, 0, 1, 32'h424, 32'hCAFE_F00D, 2'd2, 0, 1, 32'h0, 0, 3, "st_alias_424");
        access(0, 1, 0, 32'h24, 32'h0, 2'd2, 0, 1, 32'hCAFE_F00D, 0, 3, "ld_24");
        access(0, 1, 0, 32'h27, 32'h0, 2'd0, 1, 1, 32'hFFFF_FFCA, 0, 3, "ld_b27_s");

        // WAIT_CYCLES=0 instance
        access(1, 0, 1, 32'h0, 32'hA5A5_7F80, 2'd2, 0, 1, 32'h0, 0, 1, "z_st_w0");
        access(1, 1, 0, 32'h0, 32'h0, 2'd2, 0, 1, 32'hA5A5_7F80, 0, 1, "z_ld_w0");
        access(1, 1, 0, 32'h2, 32'h0, 2'd1, 0, 1, 32'h0000_A5A5, 0, 1, "z_ld_h2_u");
        access(1, 1, 0, 32'h0, 32'h0, 2'd0, 1, 1, 32'hFFFF_FF80, 0, 1, "z_ld_b0_s");
        access(1, 1, 0, 32'h1, 32'h0, 2'd0, 1, 1, 32'h0000_007F, 0, 1, "z_ld_b1_s");
        access(1, 0, 1, 32'h3, 32'h0000_0012, 2'd0, 0, 1, 32'h0, 0, 1, "z_st_b3");
        access(1, 1, 0, 32'h0, 32'h0, 2'd2, 0, 1, 32'h12A5_7F80, 0, 1, "z_ld_w0_b");
        access(1, 1, 0, 32'h1, 32'h0, 2'd2, 0, 1, 32'h0, 1, 1, "z_ld_w1_err");

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
